// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster timing constants for the VGA timing generator.
// Holds the default 640x480@60 set, an 800x600@72 alternate set and the
// helper that sums one axis into its total period.
package vga_timing_pkg;

  // 640x480@60 (25.175 MHz nominal pixel clock, negative syncs)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_HS_POL   = 1'b0;
  localparam bit VGA640_VS_POL   = 1'b0;

  // 800x600@72 (50 MHz pixel clock, positive syncs)
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 56;
  localparam int SVGA800_H_SYNC   = 120;
  localparam int SVGA800_H_BP     = 64;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 37;
  localparam int SVGA800_V_SYNC   = 6;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_HS_POL   = 1'b1;
  localparam bit SVGA800_VS_POL   = 1'b1;

  // Total period of one axis: visible region plus both porches and the sync pulse
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one raster axis (horizontal or vertical). Owns the position
// counter and decodes the value the counter will hold after this clock, so
// the parent can register every output against the same pixel.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = VGA640_H_ACTIVE,
  parameter int FP     = VGA640_H_FP,
  parameter int SYNC   = VGA640_H_SYNC,
  parameter int BP     = VGA640_H_BP,
  parameter bit POL    = 1'b0,
  parameter int CNT_W  = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] cnt_next,
  output logic             wrap,
  output logic             sync_next,
  output logic             active_next,
  output logic             first_next,
  output logic             last_next
);

  localparam int               TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt;
  logic             in_sync;

  // Counter never goes past TOTAL-1; equality compare keeps the wrap exact
  assign wrap = (cnt == LAST_CNT);

  // Upcoming position and its region decode (equals cnt when not stepping)
  always_comb begin
    cnt_next = cnt;
    if (step) begin
      cnt_next = wrap ? '0 : cnt + ONE;
    end
    in_sync     = (cnt_next >= SYNC_START) && (cnt_next < SYNC_END);
    sync_next   = in_sync ? POL : ~POL;
    active_next = (cnt_next < ACT_END);
    first_next  = (cnt_next == '0);
    last_next   = (cnt_next == ACT_LAST);
  end

  // Reset parks the counter on its last value so the first step lands on 0
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= LAST_CNT;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with pixel clock-enable,
// selectable sync polarity, fully registered outputs and line/frame markers.
// Optional feature macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = VGA640_HS_POL,
  parameter bit VS_POL   = VGA640_VS_POL,
  parameter int CNT_W    = 11
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             video_on,
  output logic             sol,
  output logic             eol,
  output logic             sof,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic             eof
);

  logic [CNT_W-1:0] h_next, v_next;
  logic             h_wrap, v_wrap;
  logic             h_sync_n, h_act_n, h_first_n, h_last_n;
  logic             v_sync_n, v_act_n, v_first_n, v_last_n;
  logic             v_step;

  assign v_step = pix_ce & h_wrap;

  vga_axis_cnt #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(HS_POL), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk25), .rst(rst), .step(pix_ce),
    .cnt_next(h_next), .wrap(h_wrap), .sync_next(h_sync_n),
    .active_next(h_act_n), .first_next(h_first_n), .last_next(h_last_n)
  );

  vga_axis_cnt #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(VS_POL), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk25), .rst(rst), .step(v_step),
    .cnt_next(v_next), .wrap(v_wrap), .sync_next(v_sync_n),
    .active_next(v_act_n), .first_next(v_first_n), .last_next(v_last_n)
  );

  // Register every output from the upcoming counter values so all of them describe the same pixel
  always_ff @(posedge clk25) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      hsync    <= ~HS_POL;
      vsync    <= ~VS_POL;
      video_on <= 1'b0;
      sol      <= 1'b0;
      eol      <= 1'b0;
      sof      <= 1'b0;
      eof      <= 1'b0;
    end else if (pix_ce) begin
      x        <= h_next;
      y        <= v_next;
      hsync    <= h_sync_n;
      vsync    <= v_sync_n;
      video_on <= h_act_n & v_act_n;
      sol      <= h_first_n;
      eol      <= h_last_n & v_act_n;
      sof      <= h_first_n & v_first_n;
      eof      <= h_last_n & v_last_n;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Count frames on the same edge that raises sof, so the first frame reads 1
  always_ff @(posedge clk25) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (pix_ce && h_first_n && v_first_n) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
